// File: rtl/multiplier_control.sv
// ---------------------------------------------------------------------------
// multiplier_control
//   Sequencer for a shift-add sequential multiplier datapath. On a start
//   request it loads the operands. It then runs WIDTH test/add/shift
//   iterations and pulses done once the last shift has completed. It owns
//   every write/shift strobe of the datapath.
//
//   Parameters
//     WIDTH  operand width, equal to the number of iterations
//     CNT_W  iteration counter width, 2**CNT_W must exceed WIDTH
//
//   Ports
//     clk, reset    rising-edge clock, synchronous active-high reset
//     start         multiply request, only honoured in IDLE
//     product_lsb   Product[0], the multiplier bit under test
//     busy          high in every state except IDLE
//     done          one-cycle completion pulse
//     mcand_wrctrl  load Multiplicand register
//     prod_load     Product <= {0, multiplier}
//     alu_add       Product[hi] += Multiplicand
//     prod_shift    Product >>= 1
//     iter_count    completed iterations
//
//   Optional feature, enabled by defining MULT_CTRL_SIGNED_EN:
//     signed_op (in)  request a two's-complement multiply, latched in LOAD
//     alu_sub   (out) Product[hi] -= Multiplicand (last iteration, sign bit)
//     prod_sra  (out) sign-filling shift, asserted with prod_shift
// ---------------------------------------------------------------------------
module multiplier_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             product_lsb,
`ifdef MULT_CTRL_SIGNED_EN
    input  logic             signed_op,
    output logic             alu_sub,
    output logic             prod_sra,
`endif
    output logic             busy,
    output logic             done,
    output logic             mcand_wrctrl,
    output logic             prod_load,
    output logic             alu_add,
    output logic             prod_shift,
    output logic [CNT_W-1:0] iter_count
);

`ifdef MULT_CTRL_SIGNED_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE, S_SUB
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mcand_wrctrl_q, mcand_wrctrl_d;
    logic             prod_load_q, prod_load_d;
    logic             alu_add_q, alu_add_d;
    logic             prod_shift_q, prod_shift_d;
`ifdef MULT_CTRL_SIGNED_EN
    logic             signed_q, signed_d;
    logic             alu_sub_q, alu_sub_d;
    logic             prod_sra_q, prod_sra_d;
`endif

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
`ifdef MULT_CTRL_SIGNED_EN
        signed_d = signed_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                iter_d  = '0;
`ifdef MULT_CTRL_SIGNED_EN
                signed_d = signed_op;
`endif
                state_d = S_TEST;
            end
            S_TEST: begin
                if (product_lsb) begin
`ifdef MULT_CTRL_SIGNED_EN
                    // Sign bit of a two's-complement multiplier carries
                    // negative weight, so it subtracts instead of adding.
                    state_d = (signed_q && (iter_q == LAST_ITER)) ? S_SUB : S_ADD;
`else
                    state_d = S_ADD;
`endif
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD: state_d = S_SHIFT;
`ifdef MULT_CTRL_SIGNED_EN
            S_SUB: state_d = S_SHIFT;
`endif
            S_SHIFT: begin
                iter_d  = iter_q + 1'b1;
                state_d = (iter_q == LAST_ITER) ? S_DONE : S_TEST;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so each
        // output flop always reflects the state register it sits beside.
        busy_d         = (state_d != S_IDLE);
        done_d         = (state_d == S_DONE);
        mcand_wrctrl_d = (state_d == S_LOAD);
        prod_load_d    = (state_d == S_LOAD);
        alu_add_d      = (state_d == S_ADD);
        prod_shift_d   = (state_d == S_SHIFT);
`ifdef MULT_CTRL_SIGNED_EN
        alu_sub_d      = (state_d == S_SUB);
        prod_sra_d     = (state_d == S_SHIFT) && signed_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            iter_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mcand_wrctrl_q <= 1'b0;
            prod_load_q    <= 1'b0;
            alu_add_q      <= 1'b0;
            prod_shift_q   <= 1'b0;
`ifdef MULT_CTRL_SIGNED_EN
            signed_q       <= 1'b0;
            alu_sub_q      <= 1'b0;
            prod_sra_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            iter_q         <= iter_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            mcand_wrctrl_q <= mcand_wrctrl_d;
            prod_load_q    <= prod_load_d;
            alu_add_q      <= alu_add_d;
            prod_shift_q   <= prod_shift_d;
`ifdef MULT_CTRL_SIGNED_EN
            signed_q       <= signed_d;
            alu_sub_q      <= alu_sub_d;
            prod_sra_q     <= prod_sra_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mcand_wrctrl = mcand_wrctrl_q;
    assign prod_load    = prod_load_q;
    assign alu_add      = alu_add_q;
    assign prod_shift   = prod_shift_q;
    assign iter_count   = iter_q;
`ifdef MULT_CTRL_SIGNED_EN
    assign alu_sub      = alu_sub_q;
    assign prod_sra     = prod_sra_q;
`endif

endmodule
